// File: rtl/uart_ram_ctrl.sv
// rtl/uart_ram_ctrl.sv - parses uart_rx command frames into RAM writes or RAM read-back through uart_tx
module uart_ram_ctrl #(
    parameter logic [7:0] CMD_WR      = 8'hA5,
    parameter logic [7:0] CMD_RD      = 8'h5A,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_bits_ok,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_idle,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_LEN, WR_DATA, RD_FETCH, RD_LATCH, RD_WAIT_IDLE, RD_WAIT_ACK
    } state_t;

    state_t        state;
    logic          rx_ok_d;
    logic          rx_stb;
    logic          is_rd;
    logic [7:0]    addr;
    logic [8:0]    remaining;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;

    assign rx_stb      = rx_bits_ok & ~rx_ok_d;
    assign timeout_hit = (tcnt == T_LAST);
    assign busy        = (state != IDLE);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rx_ok_d    <= 1'b0;
            is_rd      <= 1'b0;
            addr       <= 8'h00;
            remaining  <= 9'd0;
            tcnt       <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= 8'h00;
            ram_wdata  <= 8'h00;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_ok_d    <= rx_bits_ok;
            ram_we     <= 1'b0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            // Bytes arriving while a read-back is running are discarded
            if (rx_stb && state inside {RD_FETCH, RD_LATCH, RD_WAIT_IDLE, RD_WAIT_ACK})
                frame_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (rx_stb) begin
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            is_rd <= (rx_data == CMD_RD);
                            tcnt  <= '0;
                            state <= GET_ADDR;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_stb) begin
                        addr  <= rx_data;
                        tcnt  <= '0;
                        state <= GET_LEN;
                    end else if (timeout_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GET_LEN: begin
                    if (rx_stb) begin
                        remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        tcnt      <= '0;
                        if (is_rd) begin
                            // Present the address early so a registered-read RAM is ready by RD_LATCH
                            ram_addr <= addr;
                            state    <= RD_FETCH;
                        end else begin
                            state <= WR_DATA;
                        end
                    end else if (timeout_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WR_DATA: begin
                    if (rx_stb) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= rx_data;
                        addr      <= addr + 8'd1;
                        remaining <= remaining - 9'd1;
                        tcnt      <= '0;
                        if (remaining == 9'd1) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RD_FETCH: begin
                    ram_addr <= addr;
                    state    <= RD_LATCH;
                end
                RD_LATCH: begin
                    tx_data <= ram_rdata;
                    state   <= RD_WAIT_IDLE;
                end
                RD_WAIT_IDLE: begin
                    if (tx_idle) begin
                        tx_start <= 1'b1;
                        state    <= RD_WAIT_ACK;
                    end
                end
                RD_WAIT_ACK: begin
                    if (!tx_idle) begin
                        addr      <= addr + 8'd1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            ram_addr <= addr + 8'd1;
                            state    <= RD_FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ram_ctrl.sv
// tb/tb_uart_ram_ctrl.sv - directed self-checking bench for uart_ram_ctrl
module tb_uart_ram_ctrl;
    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_bits_ok = 1'b0;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_idle = 1'b1;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    uart_ram_ctrl dut (
        .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_bits_ok(rx_bits_ok),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_start(tx_start), .tx_idle(tx_idle), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0]  mem [256];
    logic [15:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          done_cnt = 0;
    int          done_we_cnt = 0;
    int          err_cnt = 0;
    int          tx_cnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    // RAM, uart_tx and output monitors all act on the falling edge
    always @(negedge sys_clk) begin
        if (ram_we) mem[ram_addr] = ram_wdata;
        ram_rdata = mem[ram_addr];
        if (!rst) begin
            if (ram_we) wr_q.push_back({ram_addr, ram_wdata});
            if (frame_done) done_cnt++;
            if (frame_done && ram_we) done_we_cnt++;
            if (frame_err) err_cnt++;
            if (tx_start) tx_q.push_back(tx_data);
        end
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_idle = 1'b1;
        end else if (tx_start && tx_idle) begin
            tx_idle = 1'b0;
            tx_cnt  = 640;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge sys_clk);
        rx_data    = b;
        rx_bits_ok = 1'b1;
        repeat (2) @(negedge sys_clk);
        rx_bits_ok = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        tx_q.delete();
        done_cnt    = 0;
        done_we_cnt = 0;
        err_cnt     = 0;
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, ram_we, ram_addr, ram_wdata, tx_start, busy, frame_done, frame_err};
    endfunction

    initial begin
        int bad;
        logic [7:0] i8;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", outs(), 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Write 3 bytes at 0x10 with 640-cycle byte spacing
        clear_logs();
        send(8'hA5, 640); send(8'h10, 640); send(8'h03, 640);
        send(8'h11, 640); send(8'h22, 640); send(8'h33, 5);
        check("wr_count", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            check("wr0", wr_q[0], 16'h1011);
            check("wr1", wr_q[1], 16'h1122);
            check("wr2", wr_q[2], 16'h1233);
        end
        check("wr_done", done_cnt, 1);
        check("wr_done_with_we", done_we_cnt, 1);
        check("wr_busy_after", busy, 0);
        check("wr_no_err", err_cnt, 0);

        // Read them back through the uart_tx model
        clear_logs();
        send(8'h5A, 10); send(8'h10, 10); send(8'h03, 2500);
        check("rd_tx_count", tx_q.size(), 3);
        if (tx_q.size() == 3) begin
            check("rd0", tx_q[0], 8'h11);
            check("rd1", tx_q[1], 8'h22);
            check("rd2", tx_q[2], 8'h33);
        end
        check("rd_done", done_cnt, 1);
        check("rd_no_we", wr_q.size(), 0);
        check("rd_busy_after", busy, 0);

        // Address wrap
        clear_logs();
        send(8'hA5, 4); send(8'hFE, 4); send(8'h03, 4);
        send(8'hAA, 4); send(8'hBB, 4); send(8'hCC, 5);
        check("wrap_count", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            check("wrap0", wr_q[0], 16'hFEAA);
            check("wrap1", wr_q[1], 16'hFFBB);
            check("wrap2", wr_q[2], 16'h00CC);
        end
        check("wrap_done", done_cnt, 1);

        // LEN=0 writes all 256 locations
        clear_logs();
        send(8'hA5, 2); send(8'h00, 2); send(8'h00, 2);
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            send(i8 ^ 8'h5C, 2);
        end
        repeat (4) @(negedge sys_clk);
        check("len0_count", wr_q.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < wr_q.size(); i++) begin
            i8 = 8'(i);
            if (wr_q[i] !== {i8, i8 ^ 8'h5C}) bad++;
        end
        check("len0_bad_entries", bad, 0);
        check("len0_done", done_cnt, 1);

        // Unknown command byte
        clear_logs();
        send(8'h00, 5);
        check("badcmd_err", err_cnt, 1);
        check("badcmd_no_we", wr_q.size(), 0);
        check("badcmd_busy", busy, 0);

        // Header timeout, then a good frame
        clear_logs();
        send(8'hA5, 4); send(8'h20, 4200);
        check("tmo_err", err_cnt, 1);
        check("tmo_idle", busy, 0);
        check("tmo_no_we", wr_q.size(), 0);
        clear_logs();
        send(8'hA5, 4); send(8'h30, 4); send(8'h01, 4); send(8'h7E, 5);
        check("tmo_next_count", wr_q.size(), 1);
        if (wr_q.size() == 1) check("tmo_next_wr", wr_q[0], 16'h307E);
        check("tmo_next_done", done_cnt, 1);

        // Stray byte during a read is dropped; memory here holds i^0x5C
        clear_logs();
        send(8'h5A, 4); send(8'h10, 4); send(8'h03, 300);
        check("drop_busy_mid", busy, 1);
        send(8'h99, 2500);
        check("drop_err", err_cnt, 1);
        check("drop_tx_count", tx_q.size(), 3);
        if (tx_q.size() == 3) begin
            check("drop_rd0", tx_q[0], 8'h4C);
            check("drop_rd1", tx_q[1], 8'h4D);
            check("drop_rd2", tx_q[2], 8'h4E);
        end
        check("drop_done", done_cnt, 1);

        // Reset in the middle of a write frame
        clear_logs();
        send(8'hA5, 4); send(8'h50, 4); send(8'h03, 4); send(8'hAB, 4);
        check("mid_first_wr", wr_q.size(), 1);
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", outs(), 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("mid_no_more_we", wr_q.size(), 1);
        check("mid_idle", busy, 0);
        clear_logs();
        send(8'hA5, 4); send(8'h40, 4); send(8'h01, 4); send(8'h55, 5);
        check("post_rst_count", wr_q.size(), 1);
        if (wr_q.size() == 1) check("post_rst_wr", wr_q[0], 16'h4055);
        check("post_rst_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_ram_ctrl.md
Name: uart_ram_ctrl

Overview:
- Downstream consumer of uart_rx. Parses received bytes into command frames and writes a 256-byte RAM or reads it back.
- Read-back bytes are handed to a uart_tx stage through a start/idle handshake.
- Sits between uart_rx (rx_data_o/rx_bits_ok) and the RAM, and drives uart_tx.
- Frame format: CMD, ADDR, LEN, then LEN data bytes for a write only.

Parameters:
CMD_WR, 8'hA5, command byte for a write frame
CMD_RD, 8'h5A, command byte for a read frame
TIMEOUT_CYC, 4096, max sys_clk cycles allowed between bytes inside a write/header frame

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_data  input  8  byte from uart_rx (rx_data_o), valid while rx_bits_ok high
rx_bits_ok  input  1  uart_rx byte-done flag; byte accepted on its rising edge only
ram_we  output  1  RAM write enable, one-cycle pulse per byte
ram_addr  output  8  RAM address (write and read)
ram_wdata  output  8  RAM write data
ram_rdata  input  8  RAM read data, valid 1 cycle after ram_addr is presented
tx_data  output  8  byte to uart_tx
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
tx_idle  input  1  uart_tx idle flag (high = ready)
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse when a frame completes normally
frame_err  output  1  one-cycle pulse on unknown CMD, timeout or byte dropped during read

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0; state IDLE; counters 0.
  - The rx_bits_ok edge register loads 0, so a level already high at release counts as an edge.
- Byte strobe: rx_stb = rx_bits_ok & ~rx_ok_d, where rx_ok_d is rx_bits_ok registered. Evaluated in cycle N.
- States: IDLE, GET_ADDR, GET_LEN, WR_DATA, RD_FETCH, RD_LATCH, RD_WAIT_IDLE, RD_WAIT_ACK.
- IDLE:
  - rx_stb with CMD_WR or CMD_RD: latch the command, go to GET_ADDR.
  - Any other byte: pulse frame_err, stay in IDLE.
- GET_ADDR: on rx_stb, latch addr, go to GET_LEN.
- GET_LEN: on rx_stb, latch len.
  - len = 0 means 256 bytes; internal 9-bit remaining count = (len==0) ? 256 : len.
  - Next state is WR_DATA for CMD_WR, RD_FETCH for CMD_RD.
- WR_DATA:
  - rx_stb in cycle N: in cycle N+1, ram_we=1, ram_addr=addr, ram_wdata=byte.
  - Then addr increments mod 256 and remaining decrements.
  - When remaining reaches 0: frame_done pulses in the same cycle as the last ram_we, then IDLE.
- RD_FETCH: drive ram_addr=addr, go to RD_LATCH.
- RD_LATCH: tx_data <= ram_rdata, go to RD_WAIT_IDLE.
- RD_WAIT_IDLE: when tx_idle=1, pulse tx_start for 1 cycle, go to RD_WAIT_ACK.
- RD_WAIT_ACK:
  - Wait for tx_idle=0, meaning uart_tx accepted the byte.
  - Then addr++ mod 256, remaining--.
  - If remaining==0: frame_done pulse, go to IDLE. Otherwise go to RD_FETCH.
- Timeout:
  - Active in GET_ADDR, GET_LEN and WR_DATA only.
  - Counter clears on entering these states and on every rx_stb; otherwise it increments.
  - At count == TIMEOUT_CYC-1 with no rx_stb: pulse frame_err, go to IDLE, no further RAM writes.
  - Read states have no timeout; they are paced by tx.
- rx_stb during any RD_* state: byte dropped, frame_err pulsed, read continues unaffected.
- rx_stb and timeout expiry in the same cycle: the byte wins and the counter clears.
- Address wrap: 0xFF increments to 0x00 with no error.
- ram_we is never high outside WR_DATA+1. tx_start is never high outside RD_WAIT_IDLE.
- Reset mid-frame aborts immediately; no partial-frame state survives.

Test Plan:
- Write frame A5 10 03 11 22 33, bytes 640 cycles apart -> exactly 3 ram_we pulses: (0x10,0x11), (0x11,0x22), (0x12,0x33); frame_done coincides with the 3rd; busy low afterwards.
- Read frame 5A 10 03 after the above, bench uart_tx model (tx_idle low 640 cycles per byte) -> tx_start three times with tx_data 0x11, 0x22, 0x33; frame_done after the 3rd accept; no ram_we.
- Wrap and LEN=0:
  - A5 FE 03 AA BB CC -> writes at 0xFE, 0xFF, 0x00.
  - A5 00 00 followed by 256 bytes -> 256 writes at 0x00..0xFF, a single frame_done.
- Errors:
  - Byte 0x00 in IDLE -> frame_err, no write.
  - A5 20 then silence for 4096 cycles -> frame_err, state IDLE; a following valid A5 30 01 7E frame writes 0x7E at 0x30.
- Drop during read: 0x99 arrives while a read is in progress -> frame_err pulse; read data sequence unchanged.
- Reset mid-operation:
  - rst=1 during WR_DATA after 1 of 3 bytes -> all outputs 0 at once, no further ram_we.
  - After release, A5 40 01 55 -> single write 0x55 at 0x40.
